// File: rtl/multichannel_energy_localizer.sv
// Multichannel FFT band-energy localizer.
// Accumulates per-channel band energy (re^2 + im^2) over the FFT bins
// LOWER_BIN..UPPER_BIN of each frame. At frame end it picks the loudest
// channel, gates it against a runtime threshold and applies HOLD_FRAMES
// hysteresis before changing the reported direction bin.
//
// Ports:
//   clk_in, rst_in         clock, asynchronous active-high reset
//   fft_data_in            NUM_MICS packed {im, re} signed pairs, channel 0 at the LSBs
//   fft_valid_in/last_in   beat valid / final beat of frame (qualified by valid)
//   fft_ready_out          high while accumulating; beats are accepted on valid && ready
//   threshold_in           minimum peak energy for an active frame, sampled during SCAN
//   bin_out                current direction channel
//   bin_valid_out          one-cycle pulse per completed frame
//   frame_active_out       peak > threshold for the last frame
//   peak_energy_out        winning channel energy of the last frame
//   frame_saturated_out    some accumulator saturated in the last frame
module multichannel_energy_localizer #(
    parameter int NUM_MICS    = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int LOWER_BIN   = 9,
    parameter int UPPER_BIN   = 180,
    parameter int ACC_WIDTH   = 48,
    parameter int HOLD_FRAMES = 3
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_MICS*2*DATA_WIDTH-1:0] fft_data_in,
    input  logic                             fft_valid_in,
    input  logic                             fft_last_in,
    output logic                             fft_ready_out,
    input  logic [ACC_WIDTH-1:0]             threshold_in,
    output logic [$clog2(NUM_MICS)-1:0]      bin_out,
    output logic                             bin_valid_out,
    output logic                             frame_active_out,
    output logic [ACC_WIDTH-1:0]             peak_energy_out,
    output logic                             frame_saturated_out
);
    localparam int BIN_W  = $clog2(NUM_MICS);
    localparam int SQ_W   = 2*DATA_WIDTH + 1;
    localparam int IDX_W  = $clog2(UPPER_BIN + 2);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int SUM_W  = ((ACC_WIDTH > SQ_W) ? ACC_WIDTH : SQ_W) + 1;
    localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(UPPER_BIN + 1);
    localparam logic [BIN_W-1:0] LAST_CH = BIN_W'(NUM_MICS - 1);

    typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_SCAN, S_DECIDE} state_t;

    // Both squares are non-negative and at most 2^(2*DW-2), so the
    // signed products fit and their sum needs exactly one extra bit.
    function automatic logic [SQ_W-1:0] energy(input logic signed [DATA_WIDTH-1:0] re,
                                               input logic signed [DATA_WIDTH-1:0] im);
        logic signed [2*DATA_WIDTH-1:0] rr;
        logic signed [2*DATA_WIDTH-1:0] ii;
        rr = re * re;
        ii = im * im;
        return {1'b0, rr} + {1'b0, ii};
    endfunction

    // Returns {overflow, clamped sum}.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [SQ_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({ACC_WIDTH{1'b1}}))
            return {1'b1, {ACC_WIDTH{1'b1}}};
        return {1'b0, s[ACC_WIDTH-1:0]};
    endfunction

    state_t                          state, state_nxt;
    logic                            drain_cnt;
    logic [BIN_W-1:0]                scan_idx;
    logic [IDX_W-1:0]                bin_idx;
    logic                            accept, in_window;
    logic                            vld_p0, vld_p1;
    logic [NUM_MICS*2*DATA_WIDTH-1:0] data_p0;
    logic [SQ_W-1:0]                 sq_p1   [NUM_MICS];
    logic [ACC_WIDTH-1:0]            acc     [NUM_MICS];
    logic [ACC_WIDTH:0]              acc_sum [NUM_MICS];
    logic                            ovf_any, sat_flag;
    logic [ACC_WIDTH-1:0]            best_val, thr_q;
    logic [BIN_W-1:0]                best_idx, candidate, cand_nxt, bin_nxt;
    logic [HOLD_W-1:0]               hold_cnt, hold_nxt;
    logic                            frame_active;

    assign accept    = fft_valid_in && fft_ready_out;
    assign in_window = (bin_idx >= IDX_W'(LOWER_BIN)) && (bin_idx <= IDX_W'(UPPER_BIN));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACCUM:  if (accept && fft_last_in) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_cnt)             state_nxt = S_SCAN;
            S_SCAN:   if (scan_idx == LAST_CH)   state_nxt = S_DECIDE;
            default:                             state_nxt = S_ACCUM;
        endcase
    end

    always_comb begin
        fft_ready_out = (state == S_ACCUM);
    end

    // Bin index saturates so over-long frames stay out of the window.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            drain_cnt <= 1'b0;
            scan_idx  <= '0;
            bin_idx   <= '0;
        end else begin
            case (state)
                S_ACCUM: if (accept) begin
                    if (fft_last_in)          bin_idx <= '0;
                    else if (bin_idx != IDX_SAT) bin_idx <= bin_idx + 1'b1;
                end
                S_DRAIN: drain_cnt <= ~drain_cnt;
                S_SCAN:  scan_idx  <= (scan_idx == LAST_CH) ? '0 : scan_idx + 1'b1;
                default: bin_idx   <= '0;
            endcase
        end
    end

    // S1: register beat and in-window qualifier
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= accept && in_window;
            vld_p1 <= vld_p0;
        end
    end

    // S2: per-channel squared magnitude
    always_ff @(posedge clk_in) begin
        data_p0 <= fft_data_in;
        for (int k = 0; k < NUM_MICS; k++)
            sq_p1[k] <= energy(data_p0[2*k*DATA_WIDTH +: DATA_WIDTH],
                               data_p0[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]);
    end

    // S3: saturating accumulation with sticky overflow flag
    always_comb begin
        ovf_any = 1'b0;
        for (int k = 0; k < NUM_MICS; k++) begin
            acc_sum[k] = sat_add(acc[k], sq_p1[k]);
            ovf_any    = ovf_any | acc_sum[k][ACC_WIDTH];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_MICS; k++) acc[k] <= '0;
            sat_flag <= 1'b0;
        end else if (state == S_DECIDE) begin
            for (int k = 0; k < NUM_MICS; k++) acc[k] <= '0;
            sat_flag <= 1'b0;
        end else if (vld_p1) begin
            for (int k = 0; k < NUM_MICS; k++) acc[k] <= acc_sum[k][ACC_WIDTH-1:0];
            sat_flag <= sat_flag | ovf_any;
        end
    end

    // Sequential argmax; strict > keeps the lowest index on ties.
    always_ff @(posedge clk_in) begin
        if (state == S_SCAN) begin
            thr_q <= threshold_in;
            if (scan_idx == '0 || acc[scan_idx] > best_val) begin
                best_val <= acc[scan_idx];
                best_idx <= scan_idx;
            end
        end
    end

    always_comb begin
        frame_active = (best_val > thr_q);
        cand_nxt     = candidate;
        hold_nxt     = hold_cnt;
        bin_nxt      = bin_out;
        if (!frame_active)              hold_nxt = '0;
        else if (best_idx == bin_out)   hold_nxt = '0;
        else if (best_idx == candidate) hold_nxt = hold_cnt + 1'b1;
        else begin
            cand_nxt = best_idx;
            hold_nxt = HOLD_W'(1);
        end
        if (hold_nxt == HOLD_W'(HOLD_FRAMES)) begin
            bin_nxt  = best_idx;
            hold_nxt = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            candidate           <= '0;
            hold_cnt            <= '0;
            bin_out             <= '0;
            bin_valid_out       <= 1'b0;
            frame_active_out    <= 1'b0;
            peak_energy_out     <= '0;
            frame_saturated_out <= 1'b0;
        end else begin
            bin_valid_out <= (state == S_DECIDE);
            if (state == S_DECIDE) begin
                candidate           <= cand_nxt;
                hold_cnt            <= hold_nxt;
                bin_out             <= bin_nxt;
                frame_active_out    <= frame_active;
                peak_energy_out     <= best_val;
                frame_saturated_out <= sat_flag;
            end
        end
    end
endmodule

// File: tb/tb_multichannel_energy_localizer.sv
module tb_multichannel_energy_localizer;
    localparam int NM  = 4;
    localparam int DW  = 16;
    localparam int LO  = 9;
    localparam int HI  = 180;
    localparam int PER = 10;
    localparam int NI  = 3;
    localparam int HOLDN [NI] = '{1, 3, 1};
    localparam int ACCW  [NI] = '{48, 48, 32};

    localparam int M_CH2 = 0, M_TIE = 1, M_OUTWIN = 2, M_WIN = 3, M_SAT = 4, M_RAND = 5;

    typedef struct packed {
        logic [1:0]  bin;
        logic        act;
        logic [63:0] pk;
        logic        sat;
    } res_t;

    typedef struct packed {
        res_t [NI-1:0] r;
        logic [63:0]   t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NM*2*DW-1:0] fft_data;
    logic              fft_valid, fft_last;
    logic [47:0]       thr;

    logic        rdy0, rdy1, rdy2, bv0, bv1, bv2, act0, act1, act2, sat0, sat1, sat2;
    logic [1:0]  bin0, bin1, bin2;
    logic [47:0] pk0, pk1;
    logic [31:0] pk2;

    logic        o_rdy [NI];
    logic        o_bv  [NI];
    logic        o_act [NI];
    logic        o_sat [NI];
    logic [1:0]  o_bin [NI];
    logic [63:0] o_pk  [NI];
    assign o_rdy[0] = rdy0; assign o_rdy[1] = rdy1; assign o_rdy[2] = rdy2;
    assign o_bv[0]  = bv0;  assign o_bv[1]  = bv1;  assign o_bv[2]  = bv2;
    assign o_act[0] = act0; assign o_act[1] = act1; assign o_act[2] = act2;
    assign o_sat[0] = sat0; assign o_sat[1] = sat1; assign o_sat[2] = sat2;
    assign o_bin[0] = bin0; assign o_bin[1] = bin1; assign o_bin[2] = bin2;
    assign o_pk[0]  = {16'b0, pk0}; assign o_pk[1] = {16'b0, pk1}; assign o_pk[2] = {32'b0, pk2};

    multichannel_energy_localizer #(.NUM_MICS(NM), .DATA_WIDTH(DW), .LOWER_BIN(LO), .UPPER_BIN(HI),
        .ACC_WIDTH(48), .HOLD_FRAMES(1)) dut_h1 (
        .clk_in(clk), .rst_in(rst), .fft_data_in(fft_data), .fft_valid_in(fft_valid),
        .fft_last_in(fft_last), .fft_ready_out(rdy0), .threshold_in(thr), .bin_out(bin0),
        .bin_valid_out(bv0), .frame_active_out(act0), .peak_energy_out(pk0),
        .frame_saturated_out(sat0));

    multichannel_energy_localizer #(.NUM_MICS(NM), .DATA_WIDTH(DW), .LOWER_BIN(LO), .UPPER_BIN(HI),
        .ACC_WIDTH(48), .HOLD_FRAMES(3)) dut_h3 (
        .clk_in(clk), .rst_in(rst), .fft_data_in(fft_data), .fft_valid_in(fft_valid),
        .fft_last_in(fft_last), .fft_ready_out(rdy1), .threshold_in(thr), .bin_out(bin1),
        .bin_valid_out(bv1), .frame_active_out(act1), .peak_energy_out(pk1),
        .frame_saturated_out(sat1));

    multichannel_energy_localizer #(.NUM_MICS(NM), .DATA_WIDTH(DW), .LOWER_BIN(LO), .UPPER_BIN(HI),
        .ACC_WIDTH(32), .HOLD_FRAMES(1)) dut_a32 (
        .clk_in(clk), .rst_in(rst), .fft_data_in(fft_data), .fft_valid_in(fft_valid),
        .fft_last_in(fft_last), .fft_ready_out(rdy2), .threshold_in(thr[31:0]), .bin_out(bin2),
        .bin_valid_out(bv2), .frame_active_out(act2), .peak_energy_out(pk2),
        .frame_saturated_out(sat2));

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    exp_t expq [$];
    longint unsigned t_last;

    // Reference direction state per instance
    int m_bin [NI];
    int m_cand [NI];
    int m_hold [NI];

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_bin[i] = 0; m_cand[i] = 0; m_hold[i] = 0;
        end
    endtask

    function automatic void beat_val(input int mode, input int w, input int p, input int k,
                                     input int amp, output int re, output int im);
        re = 0; im = 0;
        case (mode)
            M_CH2:    if (k == 2) re = 1000;
            M_TIE:    if (k == 1 || k == 3) re = 500;
            M_OUTWIN: if (k == 3 && (p < LO || p > HI)) re = 1000;
            M_WIN:    re = (k == w) ? 1000 : 300;
            M_SAT:    begin re = -32768; im = -32768; end
            default:  begin
                re = int'($urandom_range(0, 2*amp)) - amp;
                im = int'($urandom_range(0, 2*amp)) - amp;
            end
        endcase
    endfunction

    // Frame result from the plain energy totals of each channel
    task automatic predict(input longint unsigned e [NM]);
        exp_t x;
        for (int i = 0; i < NI; i++) begin
            longint unsigned mx, pk, c, th;
            int w;
            bit sat, act;
            mx = (64'd1 << ACCW[i]) - 64'd1;
            pk = 0; w = 0; sat = 0;
            for (int k = 0; k < NM; k++) begin
                c = (e[k] > mx) ? mx : e[k];
                if (e[k] > mx) sat = 1;
                if (c > pk) begin pk = c; w = k; end
            end
            th  = longint'(thr) & mx;
            act = (pk > th);
            if (!act)                m_hold[i] = 0;
            else if (w == m_bin[i])  m_hold[i] = 0;
            else if (w == m_cand[i]) m_hold[i]++;
            else begin m_cand[i] = w; m_hold[i] = 1; end
            if (m_hold[i] == HOLDN[i]) begin m_bin[i] = w; m_hold[i] = 0; end
            x.r[i].bin = 2'(m_bin[i]);
            x.r[i].act = act;
            x.r[i].pk  = pk;
            x.r[i].sat = sat;
        end
        x.t = t_last + 64'((NM + 4) * PER);
        expq.push_back(x);
    endtask

    task automatic drive_beat(input logic [NM*2*DW-1:0] d, input bit last);
        int guard = 0;
        fft_data  = d;
        fft_valid = 1'b1;
        fft_last  = last;
        while (!rdy0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, expected 1", guard);
            finish_test();
        end
        t_last = longint'($time);
        @(negedge clk);
    endtask

    task automatic send_frame(input int mode, input int len, input int w, input bit expect_pulse);
        longint unsigned e [NM];
        int amp [NM];
        int re, im;
        logic [NM*2*DW-1:0] d;
        for (int k = 0; k < NM; k++) begin
            e[k]   = 0;
            amp[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300))
                                                 : int'($urandom_range(0, 32767));
        end
        for (int p = 0; p < len; p++) begin
            for (int k = 0; k < NM; k++) begin
                beat_val(mode, w, p, k, amp[k], re, im);
                d[k*2*DW +: DW]      = 16'(re);
                d[k*2*DW + DW +: DW] = 16'(im);
                if (p >= LO && p <= HI)
                    e[k] += 64'(longint'(re) * longint'(re) + longint'(im) * longint'(im));
            end
            drive_beat(d, p == len - 1);
        end
        if (expect_pulse) predict(e);
    endtask

    task automatic wait_idle();
        int guard = 0;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        while (expq.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("idle_pending_frames", 64'(expq.size()), 0);
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_bin_%0d", tag, i), 64'(o_bin[i]), 0);
            check($sformatf("%s_valid_%0d", tag, i), 64'(o_bv[i]), 0);
            check($sformatf("%s_active_%0d", tag, i), 64'(o_act[i]), 0);
            check($sformatf("%s_peak_%0d", tag, i), o_pk[i], 0);
            check($sformatf("%s_sat_%0d", tag, i), 64'(o_sat[i]), 0);
        end
    endtask

    task automatic do_reset(input string tag);
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs(tag);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("%s_ready_%0d", tag, i), 64'(o_rdy[i]), 1);
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk);
            if (o_bv[0] || o_bv[1] || o_bv[2]) begin
                n_pulses++;
                if (expq.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    x = expq.pop_front();
                    check("pulse_time", longint'($time), x.t);
                    for (int i = 0; i < NI; i++) begin
                        check($sformatf("pulse_valid_%0d", i), 64'(o_bv[i]), 1);
                        check($sformatf("pulse_ready_%0d", i), 64'(o_rdy[i]), 1);
                        check($sformatf("bin_%0d", i), 64'(o_bin[i]), 64'(x.r[i].bin));
                        check($sformatf("active_%0d", i), 64'(o_act[i]), 64'(x.r[i].act));
                        check($sformatf("peak_%0d", i), o_pk[i], x.r[i].pk);
                        check($sformatf("sat_%0d", i), 64'(o_sat[i]), 64'(x.r[i].sat));
                    end
                end
            end
        end
    endtask

    initial begin
        int pulses_before;
        rst       = 1'b1;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        fft_data  = '0;
        thr       = '0;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("reset_ready_%0d", i), 64'(o_rdy[i]), 1);

        // Directed frames, back to back with valid held during DRAIN/SCAN
        send_frame(M_CH2, 256, 0, 1);
        send_frame(M_TIE, 256, 0, 1);
        send_frame(M_OUTWIN, 256, 0, 1);
        send_frame(M_CH2, 200, 0, 1);
        wait_idle();

        thr = 48'd1000000000000;
        send_frame(M_CH2, 256, 0, 1);
        wait_idle();
        thr = 48'd100000000;
        send_frame(M_TIE, 256, 0, 1);
        wait_idle();
        thr = '0;
        send_frame(M_SAT, 256, 0, 1);
        send_frame(M_CH2, 5, 0, 1);
        send_frame(M_WIN, 300, 1, 1);
        wait_idle();

        // Randomized frames in two threshold regimes
        for (int g = 0; g < 2; g++) begin
            thr = 48'($urandom) << $urandom_range(0, 10);
            for (int f = 0; f < 8; f++)
                send_frame(M_RAND, int'($urandom_range(1, 260)), 0, 1);
            wait_idle();
        end

        // Hysteresis sequence from a known direction
        do_reset("rst_hyst");
        thr = '0;
        send_frame(M_WIN, 190, 2, 1);
        send_frame(M_WIN, 190, 2, 1);
        send_frame(M_WIN, 190, 1, 1);
        send_frame(M_WIN, 190, 2, 1);
        send_frame(M_WIN, 190, 2, 1);
        send_frame(M_WIN, 190, 2, 1);
        wait_idle();

        // Reset while scanning aborts the frame
        send_frame(M_CH2, 256, 0, 0);
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pulses_before = n_pulses;
        do_reset("rst_scan");
        repeat (15) @(negedge clk);
        check("aborted_frame_pulses", 64'(n_pulses), 64'(pulses_before));
        send_frame(M_TIE, 256, 0, 1);
        send_frame(M_CH2, 256, 0, 1);
        wait_idle();

        check("final_queue_empty", 64'(expq.size()), 0);
        finish_test();
    end
endmodule

// File: doc/multichannel_energy_localizer.md
Name: multichannel_energy_localizer

Overview:
- Parametrised successor to the fixed 4-mic localizer.
- Accepts one packed FFT beat per frequency bin for NUM_MICS channels and accumulates per-channel band energy (re²+im²) over a bin window.
- At frame end, scans for the loudest channel, gates the result against a runtime threshold, and applies N-frame hysteresis before changing the reported direction bin.
- Sits between the FFT output stream and the direction display/UART logic.

Parameters:
NUM_MICS, 4, number of channels; also the number of output bins (2..16)
DATA_WIDTH, 16, signed width of each re/im component
LOWER_BIN, 9, first FFT bin index included (inclusive)
UPPER_BIN, 180, last FFT bin index included (inclusive)
ACC_WIDTH, 48, per-channel energy accumulator width, unsigned, saturating
HOLD_FRAMES, 3, consecutive winning frames required to change bin_out (>=1)

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-high reset
fft_data_in  in  NUM_MICS*2*DATA_WIDTH  channel k at bits [(2k+2)*DW-1 : 2k*DW]; within a channel im is the upper half, re the lower half; both signed
fft_valid_in  in  1  beat valid
fft_last_in  in  1  final beat of the frame; qualified by valid
fft_ready_out  out  1  block accepts a beat
threshold_in  in  ACC_WIDTH  minimum peak energy for a frame to count; sampled in SCAN
bin_out  out  $clog2(NUM_MICS)  current direction channel
bin_valid_out  out  1  one-cycle pulse per completed frame
frame_active_out  out  1  peak energy > threshold this frame; valid with the pulse, held until the next pulse
peak_energy_out  out  ACC_WIDTH  winning channel energy; held until the next pulse
frame_saturated_out  out  1  any accumulator saturated this frame; held until the next pulse

Behaviour:
- Reset (async): all outputs 0; state ACCUM; fft_ready_out is 1 after reset release; accumulators, bin counter, candidate and hold counter are 0.
- Beat accepted = fft_valid_in && fft_ready_out.
- Bin counter:
  - Counts accepted beats, starting at 0 on the first beat after reset or after a last beat.
  - Saturates at UPPER_BIN+1.
  - A beat is in-window iff LOWER_BIN <= idx <= UPPER_BIN.
- Pipeline:
  - S1 registers the data and the in-window flag.
  - S2 computes re*re + im*im per channel (2*DW+1 bits, unsigned).
  - S3 adds the result into the channel accumulator, saturating at 2^ACC_WIDTH-1 and setting a sticky sat flag.
- FSM states:
  - ACCUM: ready=1. Accepting a last beat moves to DRAIN.
  - DRAIN: 2 cycles, ready=0, lets S2/S3 complete.
  - SCAN: NUM_MICS cycles, ready=0. Sequential argmax over channels 0..NUM_MICS-1 using strict > so ties go to the lowest index.
  - DECIDE: 1 cycle, ready=0. Applies the gate and hysteresis, registers the outputs, clears the accumulators, the sat flag and the bin counter, then returns to ACCUM.
- Timing:
  - bin_valid_out pulses the cycle after DECIDE, exactly NUM_MICS+4 cycles after the edge that accepted the last beat.
  - fft_ready_out is 1 in that same cycle.
- Gate: active = peak > threshold_in, strict. An empty window gives peak 0, which is inactive for any threshold.
- Hysteresis, evaluated in DECIDE:
  - Inactive frame: hold counter := 0; bin_out unchanged.
  - Winner == bin_out: hold counter := 0.
  - Winner == candidate: hold counter += 1.
  - Otherwise: candidate := winner, hold counter := 1.
  - If hold counter (post-update) == HOLD_FRAMES: bin_out := winner, hold counter := 0.
  - bin_out reflects the post-update value in the pulse cycle.
  - HOLD_FRAMES=1 means immediate switching.
- Out-of-window beats in ACCUM are accepted and ignored.
- A last beat outside the window still ends the frame.
- fft_valid_in while ready=0 is neither accepted nor counted; the producer must hold the beat.
- Frames longer than UPPER_BIN+1 beats: the counter saturates and extra beats are ignored until last.
- Reset mid-frame or mid-SCAN aborts the frame; no pulse is emitted.

Test Plan:
- 256-beat frame, ch2 re=1000/im=0 in-window, others 0; HOLD=1; threshold=0 -> pulse at T_last+8; bin_out=2; peak=172*10^6; active=1.
- Tie: ch1=ch3 amplitude 500 -> winner 1.
- Energy on ch3 only at bins 0..8 and 181..255 -> peak 0; active=0; bin_out unchanged; hold counter cleared.
- HOLD=3: bin_out=0, frames win 2,2,1,2,2,2 -> bin_out becomes 2 only at the 6th pulse.
- Threshold 10^12 with peak 1.72*10^8 -> active=0. Threshold 10^8 -> active=1.
- ACC_WIDTH=32, all channels re=im=-32768 -> frame_saturated_out=1, peak=2^32-1.
- Reset during SCAN -> no pulse; outputs 0; next frame decodes normally.
- valid held high during DRAIN/SCAN -> no extra beats counted; next frame's bin index 0 maps to the first beat accepted after ready returns.
